cnn_maxp_kxk_stream: RTL

- Parametrised streaming max-pool for the DeepLabV3+ pipeline; successor to the fixed 3x3 max-pool test top.
- Takes a channel-interleaved raster pixel stream and produces non-overlapping KERNEL x KERNEL max-pool outputs (stride == KERNEL).
- Supports signed/unsigned compare, floor/ceil edge handling, and a valid/ready handshake on both sides backed by an internal output FIFO.
- Uses a separable datapath: a per-channel row accumulator plus a column buffer of partial maxima. No full line-buffer window.

---
 rtl/cnn_maxp_kxk_stream.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cnn_maxp_kxk_stream.sv
// Streaming KERNEL x KERNEL max-pool (stride == KERNEL) over a channel-interleaved raster.
// Separable datapath: per-channel row accumulator, column buffer of partial maxima, output FIFO.
module cnn_maxp_kxk_stream #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 16,
  parameter int IMAGE_HEIGHT = 16,
  parameter int CHANNEL_NUM  = 4,
  parameter int KERNEL       = 2,
  parameter int CEIL_MODE    = 0,
  parameter int SIGNED_CMP   = 1,
  parameter int OUT_DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  input  logic                  out_ready,
  output logic                  frame_done
);
  localparam int OWB = (IMAGE_WIDTH + KERNEL - 1) / KERNEL;
  localparam int OHB = (IMAGE_HEIGHT + KERNEL - 1) / KERNEL;
  localparam int OW  = (CEIL_MODE != 0) ? OWB : IMAGE_WIDTH / KERNEL;
  localparam int OH  = (CEIL_MODE != 0) ? OHB : IMAGE_HEIGHT / KERNEL;
  localparam int CW  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int XW  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int YW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int KW  = $clog2(KERNEL);
  localparam int OXW = (OWB > 1) ? $clog2(OWB) : 1;
  localparam int OYW = (OHB > 1) ? $clog2(OHB) : 1;
  localparam int CBN = OWB * CHANNEL_NUM;
  localparam int CBW = (CBN > 1) ? $clog2(CBN) : 1;
  localparam int AW  = $clog2(OUT_DEPTH);

  function automatic logic [DATA_WIDTH-1:0] vmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    if (SIGNED_CMP != 0) return ($signed(a) > $signed(b)) ? a : b;
    else                 return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]  c;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [KW-1:0]  kx, ky;
  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;

  logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] colbuf [CBN];
  logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_vld;
  logic [DATA_WIDTH-1:0] push_data;

  logic fire, last_c, last_x, last_y, hclose, vclose, in_win, pop;
  logic [CBW-1:0] cb_idx;
  logic [DATA_WIDTH-1:0] row, col;

  assign fire   = valid_in & in_ready;
  assign last_c = (c == CW'(CHANNEL_NUM - 1));
  assign last_x = (x == XW'(IMAGE_WIDTH - 1));
  assign last_y = (y == YW'(IMAGE_HEIGHT - 1));
  assign hclose = (kx == KW'(KERNEL - 1)) || ((CEIL_MODE != 0) && last_x);
  assign vclose = (ky == KW'(KERNEL - 1)) || ((CEIL_MODE != 0) && last_y);
  // Floor-mode edge beats map to ox >= OW or oy >= OH and fall outside every window.
  assign in_win = (32'(ox) < 32'(OW)) && (32'(oy) < 32'(OH));
  assign cb_idx = CBW'(32'(ox) * 32'(CHANNEL_NUM) + 32'(c));
  assign row    = (kx == '0) ? pxl_in : vmax(acc[c], pxl_in);
  assign col    = (ky == '0) ? row : vmax(colbuf[cb_idx], row);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c <= '0; x <= '0; y <= '0; kx <= '0; ky <= '0; ox <= '0; oy <= '0;
    end else if (fire) begin
      if (!last_c) begin
        c <= c + CW'(1);
      end else begin
        c <= '0;
        if (last_x) begin
          x <= '0; kx <= '0; ox <= '0;
          if (last_y) begin
            y <= '0; ky <= '0; oy <= '0;
          end else begin
            y <= y + YW'(1);
            if (ky == KW'(KERNEL - 1)) begin
              ky <= '0; oy <= oy + OYW'(1);
            end else begin
              ky <= ky + KW'(1);
            end
          end
        end else begin
          x <= x + XW'(1);
          if (kx == KW'(KERNEL - 1)) begin
            kx <= '0; ox <= ox + OXW'(1);
          end else begin
            kx <= kx + KW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else begin
      for (int i = 0; i < CHANNEL_NUM; i++)
        if (fire && c == CW'(i)) acc[i] <= row;
    end
  end

  // No reset needed: ky==0 always overwrites an entry before it is read.
  always_ff @(posedge clk) begin
    if (fire && hclose && in_win && !vclose) colbuf[cb_idx] <= col;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_vld   <= 1'b0;
      push_data  <= '0;
      frame_done <= 1'b0;
    end else begin
      push_vld   <= fire && hclose && vclose && in_win;
      push_data  <= col;
      frame_done <= fire && last_c && last_x && last_y;
    end
  end

  assign valid_out = (count != '0);
  assign pop       = valid_out & out_ready;
  assign pxl_out   = valid_out ? mem[rd_ptr] : '0;
  // The staged push counts as occupied so every accepted beat is guaranteed a slot.
  assign in_ready  = (32'(count) + 32'(push_vld)) < 32'(OUT_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
